// File: rtl/i8080_rx.sv
// i8080_rx: MIPI-DBI Type-B write-bus receiver, oversampled on PixelClk, feeding the pixel FIFO.
// Define I8080_BUS8_EN for an 8-bit bus where each pixel takes two writes, high byte first.
`default_nettype none

module i8080_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int H_ACTIVE    = 800,
   parameter int V_ACTIVE    = 480
) (
   input  logic        PixelClk,
   input  logic        nRST,
   input  logic        LCD_nCS,
   input  logic        LCD_nWR,
   input  logic        LCD_DC,
   input  logic [15:0] LCD_DB,
   input  logic        FIFO_Full,
   output logic        FIFO_WE,
   output logic [15:0] FIFO_WData,
   output logic        FRAME_Start,
   output logic        FRAME_Done,
   output logic        Overflow,
   output logic        Busy
);

   localparam int          c_LAST    = SYNC_STAGES - 1;
   localparam logic [15:0] c_H_LAST  = 16'(H_ACTIVE - 1);
   localparam logic [15:0] c_V_LAST  = 16'(V_ACTIVE - 1);
   localparam logic [19:0] c_TOTAL   = 20'(H_ACTIVE * V_ACTIVE);

   localparam logic [1:0]  c_IDLE    = 2'd0;
   localparam logic [1:0]  c_PARAM   = 2'd1;
   localparam logic [1:0]  c_RAMWR   = 2'd2;
   localparam logic [1:0]  c_IGNORE  = 2'd3;

   localparam logic [7:0]  c_CASET   = 8'h2A;
   localparam logic [7:0]  c_PASET   = 8'h2B;
   localparam logic [7:0]  c_RAMWRC  = 8'h2C;
   localparam logic [7:0]  c_SWRESET = 8'h01;

   // Idle-high reset on the strobe synchronizers so reset release never looks like a write.
   logic [SYNC_STAGES-1:0]       ncs_sync_q, nwr_sync_q, dc_sync_q;
   logic [SYNC_STAGES-1:0][15:0] db_sync_q;
   logic                         nwr_prev_q;

   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         ncs_sync_q <= '1;
         nwr_sync_q <= '1;
         dc_sync_q  <= '0;
         db_sync_q  <= '0;
         nwr_prev_q <= 1'b1;
      end else begin
         ncs_sync_q <= {ncs_sync_q[SYNC_STAGES-2:0], LCD_nCS};
         nwr_sync_q <= {nwr_sync_q[SYNC_STAGES-2:0], LCD_nWR};
         dc_sync_q  <= {dc_sync_q[SYNC_STAGES-2:0], LCD_DC};
         db_sync_q  <= {db_sync_q[SYNC_STAGES-2:0], LCD_DB};
         nwr_prev_q <= nwr_sync_q[c_LAST];
      end
   end

   logic        wr_evt, cmd_evt, dat_evt;
   logic [15:0] db;
   logic [7:0]  byte8;

   assign wr_evt  = nwr_sync_q[c_LAST] & ~nwr_prev_q & ~ncs_sync_q[c_LAST];
   assign cmd_evt = wr_evt & ~dc_sync_q[c_LAST];
   assign dat_evt = wr_evt &  dc_sync_q[c_LAST];
   assign db      = db_sync_q[c_LAST];
   assign byte8   = db[7:0];

   logic [1:0]  state_q, state_d;
   logic        target_col_q, target_col_d;
   logic [1:0]  pcnt_q, pcnt_d;
   logic [23:0] pbuf_q, pbuf_d;
   logic [15:0] cs_q, cs_d, ce_q, ce_d, ps_q, ps_d, pe_q, pe_d;
   logic [19:0] total_q, total_d, pix_q, pix_d;
   logic        we_q, we_d, start_q, start_d, done_q, done_d, ovf_q, ovf_d;
   logic [15:0] wdata_q, wdata_d;
`ifdef I8080_BUS8_EN
   logic        hi_valid_q, hi_valid_d;
   logic [7:0]  hi_q, hi_d;
`endif

   function automatic logic [15:0] clamp(input logic [15:0] v, input logic [15:0] lim);
      return (v > lim) ? lim : v;
   endfunction

   // Result of a completed 4-byte window parameter sequence.
   logic [15:0] lim, p_start, p_end;
   logic [19:0] span, col_span, page_span, new_total;

   always_comb begin
      lim       = target_col_q ? c_H_LAST : c_V_LAST;
      p_start   = clamp(pbuf_q[23:8], lim);
      p_end     = clamp({pbuf_q[7:0], byte8}, lim);
      span      = {4'd0, p_end - p_start} + 20'd1;
      col_span  = {4'd0, ce_q - cs_q} + 20'd1;
      page_span = {4'd0, pe_q - ps_q} + 20'd1;
      new_total = target_col_q ? (span * page_span) : (col_span * span);
   end

   logic        pix_evt;
   logic [15:0] pix_data;

   always_comb begin
      state_d      = state_q;
      target_col_d = target_col_q;
      pcnt_d       = pcnt_q;
      pbuf_d       = pbuf_q;
      cs_d         = cs_q;
      ce_d         = ce_q;
      ps_d         = ps_q;
      pe_d         = pe_q;
      total_d      = total_q;
      pix_d        = pix_q;
      ovf_d        = ovf_q;
      wdata_d      = wdata_q;
      we_d         = 1'b0;
      start_d      = 1'b0;
      done_d       = 1'b0;
      pix_evt      = 1'b0;
      pix_data     = db;
`ifdef I8080_BUS8_EN
      hi_valid_d   = hi_valid_q;
      hi_d         = hi_q;
`endif

      if (cmd_evt) begin
         pcnt_d = 2'd0;
`ifdef I8080_BUS8_EN
         hi_valid_d = 1'b0;
`endif
         case (byte8)
            c_CASET: begin
               state_d      = c_PARAM;
               target_col_d = 1'b1;
            end
            c_PASET: begin
               state_d      = c_PARAM;
               target_col_d = 1'b0;
            end
            c_RAMWRC: begin
               state_d = c_RAMWR;
               pix_d   = 20'd0;
               start_d = 1'b1;
               ovf_d   = 1'b0;
            end
            c_SWRESET: begin
               state_d = c_IDLE;
               cs_d    = 16'd0;
               ce_d    = c_H_LAST;
               ps_d    = 16'd0;
               pe_d    = c_V_LAST;
               total_d = c_TOTAL;
               ovf_d   = 1'b0;
            end
            default: state_d = c_IGNORE;
         endcase
      end else if (dat_evt) begin
         case (state_q)
            c_PARAM: begin
               if (pcnt_q == 2'd3) begin
                  state_d = c_IDLE;
                  if (p_end >= p_start) begin
                     total_d = new_total;
                     if (target_col_q) begin
                        cs_d = p_start;
                        ce_d = p_end;
                     end else begin
                        ps_d = p_start;
                        pe_d = p_end;
                     end
                  end
               end else begin
                  pbuf_d = {pbuf_q[15:0], byte8};
                  pcnt_d = pcnt_q + 2'd1;
               end
            end
            c_RAMWR: begin
`ifdef I8080_BUS8_EN
               if (hi_valid_q) begin
                  pix_evt    = 1'b1;
                  pix_data   = {hi_q, byte8};
                  hi_valid_d = 1'b0;
               end else begin
                  hi_d       = byte8;
                  hi_valid_d = 1'b1;
               end
`else
               pix_evt = 1'b1;
`endif
            end
            default: ;
         endcase
      end

      // Dropped pixels still advance the counter so FRAME_Done stays frame-aligned.
      if (pix_evt) begin
         if (FIFO_Full) begin
            ovf_d = 1'b1;
         end else begin
            we_d    = 1'b1;
            wdata_d = pix_data;
         end
         if (pix_q == total_q - 20'd1) begin
            done_d = 1'b1;
            pix_d  = 20'd0;
         end else begin
            pix_d = pix_q + 20'd1;
         end
      end
   end

   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         state_q      <= c_IDLE;
         target_col_q <= 1'b1;
         pcnt_q       <= 2'd0;
         pbuf_q       <= 24'd0;
         cs_q         <= 16'd0;
         ce_q         <= c_H_LAST;
         ps_q         <= 16'd0;
         pe_q         <= c_V_LAST;
         total_q      <= c_TOTAL;
         pix_q        <= 20'd0;
         we_q         <= 1'b0;
         start_q      <= 1'b0;
         done_q       <= 1'b0;
         ovf_q        <= 1'b0;
         wdata_q      <= 16'd0;
`ifdef I8080_BUS8_EN
         hi_valid_q   <= 1'b0;
         hi_q         <= 8'd0;
`endif
      end else begin
         state_q      <= state_d;
         target_col_q <= target_col_d;
         pcnt_q       <= pcnt_d;
         pbuf_q       <= pbuf_d;
         cs_q         <= cs_d;
         ce_q         <= ce_d;
         ps_q         <= ps_d;
         pe_q         <= pe_d;
         total_q      <= total_d;
         pix_q        <= pix_d;
         we_q         <= we_d;
         start_q      <= start_d;
         done_q       <= done_d;
         ovf_q        <= ovf_d;
         wdata_q      <= wdata_d;
`ifdef I8080_BUS8_EN
         hi_valid_q   <= hi_valid_d;
         hi_q         <= hi_d;
`endif
      end
   end

   assign FIFO_WE     = we_q;
   assign FIFO_WData  = wdata_q;
   assign FRAME_Start = start_q;
   assign FRAME_Done  = done_q;
   assign Overflow    = ovf_q;
   assign Busy        = (state_q == c_RAMWR);

endmodule

`default_nettype wire
